pc_sequencer: RTL and testbench

- Parametrised next-generation program counter for the single-cycle/pipelined ARM-LP core; drives the instruction-memory read address every cycle.
- Adds the following over the basic PC:
  - configurable address/offset widths and instruction-size shift
  - reset vector
  - fetch stall
  - CBZ/CBNZ condition selection
  - register-indirect branch (BR)
  - branch-with-link (BL) feeding a small return-address stack (RAS) consumed by RET.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the program-counter sequencer: decode/ALU controls in,
// fetch address, scaled offset, link address and RAS status out.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 26
);
  logic                    stall;
  logic                    branchFlag;
  logic                    branchNotZero;
  logic                    unconditionalBranchFlag;
  logic                    zeroFlag;
  logic                    linkFlag;
  logic                    registerBranch;
  logic                    returnFlag;
  logic [ADDR_WIDTH-1:0]   registerTarget;
  logic [OFFSET_WIDTH-1:0] PCOffsetOrig;
  logic [ADDR_WIDTH-1:0]   readAddress;
  logic [ADDR_WIDTH-1:0]   PCScaledOffset;
  logic [ADDR_WIDTH-1:0]   linkAddress;
  logic                    rasEmpty;
  logic                    rasFull;
  logic                    rasOverflow;

  modport master (
    output stall, branchFlag, branchNotZero, unconditionalBranchFlag, zeroFlag,
           linkFlag, registerBranch, returnFlag, registerTarget, PCOffsetOrig,
    input  readAddress, PCScaledOffset, linkAddress, rasEmpty, rasFull, rasOverflow
  );

  modport slave (
    input  stall, branchFlag, branchNotZero, unconditionalBranchFlag, zeroFlag,
           linkFlag, registerBranch, returnFlag, registerTarget, PCOffsetOrig,
    output readAddress, PCScaledOffset, linkAddress, rasEmpty, rasFull, rasOverflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with reset vector, stall, CBZ/CBNZ, BR, BL and a circular
// return-address stack consumed by RET.
module pc_sequencer #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            OFFSET_WIDTH = 26,
  parameter int unsigned            INSTR_SHIFT  = 2,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned            RAS_DEPTH    = 4
) (
  input  logic              clock,
  input  logic              resetN,
  pc_sequencer_if.slave     bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(1) << INSTR_SHIFT;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << INSTR_SHIFT;
  localparam logic [PTR_W:0]        DEPTH_CNT  = (PTR_W + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_OFFSET,
    SRC_REG,
    SRC_RAS
  } pc_src_e;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] scaled_q;
  logic [ADDR_WIDTH-1:0] link_q;
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      top_q;
  logic [PTR_W:0]        count_q;
  logic                  overflow_q;

  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] off_ext;
  logic [ADDR_WIDTH-1:0] scaled;
  logic [ADDR_WIDTH-1:0] reg_target;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [PTR_W-1:0]      top_inc;
  logic [PTR_W-1:0]      top_dec;
  logic                  ras_empty;
  logic                  ras_full;
  logic                  taken;
  logic                  push;
  logic                  pop;
  pc_src_e               src;

  assign seq        = pc_q + INC;
  assign off_ext    = ADDR_WIDTH'($signed(bus.PCOffsetOrig));
  assign scaled     = off_ext << INSTR_SHIFT;
  assign reg_target = bus.registerTarget & ALIGN_MASK;
  assign top_inc    = top_q + PTR_W'(1);
  assign top_dec    = top_q - PTR_W'(1);

  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == DEPTH_CNT);

  assign taken = bus.unconditionalBranchFlag
               | (bus.branchFlag & (bus.zeroFlag ^ bus.branchNotZero));

  // RET outranks BL/BR, so a push can never coincide with a pop.
  assign pop  = bus.returnFlag & ~ras_empty;
  assign push = bus.linkFlag & bus.unconditionalBranchFlag
              & ~bus.returnFlag & ~bus.registerBranch;

  always_comb begin
    src = SRC_SEQ;
    if (pop)                                        src = SRC_RAS;
    else if (bus.returnFlag || bus.registerBranch)  src = SRC_REG;
    else if (taken)                                 src = SRC_OFFSET;
  end

  always_comb begin
    next_pc = seq;
    case (src)
      SRC_RAS:    next_pc = ras_mem[top_q];
      SRC_REG:    next_pc = reg_target;
      SRC_OFFSET: next_pc = pc_q + scaled;
      default:    next_pc = seq;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q       <= RESET_VECTOR;
      scaled_q   <= '0;
      link_q     <= '0;
      top_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q     <= next_pc;
      scaled_q <= scaled;
      if (push) begin
        link_q <= seq;
        top_q  <= top_inc;
        // When full, top+1 is the oldest entry, so the write evicts it.
        if (ras_full) overflow_q <= 1'b1;
        else          count_q    <= count_q + 1'b1;
      end else if (pop) begin
        top_q   <= top_dec;
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetN && !bus.stall && push) ras_mem[top_inc] <= seq;
  end

  assign bus.readAddress    = pc_q;
  assign bus.PCScaledOffset = scaled_q;
  assign bus.linkAddress    = link_q;
  assign bus.rasEmpty       = ras_empty;
  assign bus.rasFull        = ras_full;
  assign bus.rasOverflow    = overflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_VECTOR=0x100 and a 4-entry RAS.
module tb_pc_sequencer;

  logic clock;
  logic resetN;
  int   checks;
  int   errors;

  pc_sequencer_if #(.ADDR_WIDTH(32), .OFFSET_WIDTH(26)) bus ();

  pc_sequencer #(
    .ADDR_WIDTH  (32),
    .OFFSET_WIDTH(26),
    .INSTR_SHIFT (2),
    .RESET_VECTOR(32'h100),
    .RAS_DEPTH   (4)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout readAddress=%h required=finish", bus.readAddress);
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    bus.stall = 1'b0;
    bus.branchFlag = 1'b0;
    bus.branchNotZero = 1'b0;
    bus.unconditionalBranchFlag = 1'b0;
    bus.zeroFlag = 1'b0;
    bus.linkFlag = 1'b0;
    bus.registerBranch = 1'b0;
    bus.returnFlag = 1'b0;
    bus.registerTarget = '0;
    bus.PCOffsetOrig = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] addr);
    clear_inputs();
    bus.registerBranch = 1'b1;
    bus.registerTarget = addr;
    tick();
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    clear_inputs();
    resetN = 1'b0;
    #12;
    checks++; if (bus.readAddress !== 32'h100) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.readAddress, 32'h100); end
    checks++; if (bus.PCScaledOffset !== 32'h0) begin errors++; $display("FAIL rst_scaled got %h exp 0", bus.PCScaledOffset); end
    checks++; if (bus.linkAddress !== 32'h0) begin errors++; $display("FAIL rst_link got %h exp 0", bus.linkAddress); end
    checks++; if ({bus.rasEmpty, bus.rasFull, bus.rasOverflow} !== 3'b100) begin errors++; $display("FAIL rst_flags got %b exp 100", {bus.rasEmpty, bus.rasFull, bus.rasOverflow}); end
    @(posedge clock); #1;
    resetN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = 32'h100 + 32'(4 * i);
      checks++; if (bus.readAddress !== exp) begin errors++; $display("FAIL seq_%0d got %h exp %h", i, bus.readAddress, exp); end
    end
    checks++; if (bus.rasEmpty !== 1'b1) begin errors++; $display("FAIL seq_empty got %b exp 1", bus.rasEmpty); end
  endtask

  task automatic test_cbz();
    do_reset();
    set_pc(32'h200);
    checks++; if (bus.readAddress !== 32'h200) begin errors++; $display("FAIL br_200 got %h exp %h", bus.readAddress, 32'h200); end
    bus.branchFlag = 1'b1; bus.PCOffsetOrig = 26'h3FFFFFE; bus.zeroFlag = 1'b1; bus.branchNotZero = 1'b0;
    tick();
    checks++; if (bus.readAddress !== 32'h1F8) begin errors++; $display("FAIL cbz_taken got %h exp %h", bus.readAddress, 32'h1F8); end
    checks++; if (bus.PCScaledOffset !== 32'hFFFFFFF8) begin errors++; $display("FAIL cbz_scaled got %h exp %h", bus.PCScaledOffset, 32'hFFFFFFF8); end
    set_pc(32'h200);
    bus.branchFlag = 1'b1; bus.PCOffsetOrig = 26'h3FFFFFE; bus.zeroFlag = 1'b1; bus.branchNotZero = 1'b1;
    tick();
    checks++; if (bus.readAddress !== 32'h204) begin errors++; $display("FAIL cbnz_not_taken got %h exp %h", bus.readAddress, 32'h204); end
    checks++; if (bus.PCScaledOffset !== 32'hFFFFFFF8) begin errors++; $display("FAIL scaled_always got %h exp %h", bus.PCScaledOffset, 32'hFFFFFFF8); end
    bus.zeroFlag = 1'b0;
    tick();
    checks++; if (bus.readAddress !== 32'h1FC) begin errors++; $display("FAIL cbnz_taken got %h exp %h", bus.readAddress, 32'h1FC); end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    set_pc(32'h40);
    bus.unconditionalBranchFlag = 1'b1; bus.linkFlag = 1'b1; bus.PCOffsetOrig = 26'd8;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.readAddress !== 32'h40) begin errors++; $display("FAIL stall_pc_%0d got %h exp %h", i, bus.readAddress, 32'h40); end
      checks++; if (bus.PCScaledOffset !== 32'h0 || bus.rasEmpty !== 1'b1 || bus.linkAddress !== 32'h0) begin
        errors++; $display("FAIL stall_hold_%0d got scaled %h empty %b link %h exp 0 1 0", i, bus.PCScaledOffset, bus.rasEmpty, bus.linkAddress);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.readAddress !== 32'h60) begin errors++; $display("FAIL stall_release got %h exp %h", bus.readAddress, 32'h60); end
    checks++; if (bus.PCScaledOffset !== 32'h20) begin errors++; $display("FAIL stall_scaled got %h exp %h", bus.PCScaledOffset, 32'h20); end
    checks++; if (bus.linkAddress !== 32'h44 || bus.rasEmpty !== 1'b0) begin errors++; $display("FAIL stall_bl got link %h empty %b exp 44 0", bus.linkAddress, bus.rasEmpty); end
    clear_inputs();
  endtask

  task automatic test_bl_ret();
    do_reset();
    set_pc(32'h300);
    bus.unconditionalBranchFlag = 1'b1; bus.linkFlag = 1'b1; bus.PCOffsetOrig = 26'h10;
    tick();
    clear_inputs();
    checks++; if (bus.readAddress !== 32'h340) begin errors++; $display("FAIL bl_pc got %h exp %h", bus.readAddress, 32'h340); end
    checks++; if (bus.linkAddress !== 32'h304) begin errors++; $display("FAIL bl_link got %h exp %h", bus.linkAddress, 32'h304); end
    checks++; if (bus.rasEmpty !== 1'b0) begin errors++; $display("FAIL bl_empty got %b exp 0", bus.rasEmpty); end
    bus.returnFlag = 1'b1;
    tick();
    checks++; if (bus.readAddress !== 32'h304) begin errors++; $display("FAIL ret_pc got %h exp %h", bus.readAddress, 32'h304); end
    checks++; if (bus.rasEmpty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", bus.rasEmpty); end
    bus.registerTarget = 32'h503;
    tick();
    checks++; if (bus.readAddress !== 32'h500) begin errors++; $display("FAIL ret_fallback got %h exp %h", bus.readAddress, 32'h500); end
    clear_inputs();
    bus.linkFlag = 1'b1;
    tick();
    checks++; if (bus.readAddress !== 32'h504 || bus.rasEmpty !== 1'b1 || bus.linkAddress !== 32'h304) begin
      errors++; $display("FAIL link_alone got pc %h empty %b link %h exp 504 1 304", bus.readAddress, bus.rasEmpty, bus.linkAddress);
    end
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp;
    do_reset();
    set_pc(32'h1000);
    for (int i = 0; i < 5; i++) begin
      bus.unconditionalBranchFlag = 1'b1; bus.linkFlag = 1'b1; bus.PCOffsetOrig = 26'h40;
      tick();
      exp = 32'h1000 + 32'(256 * (i + 1));
      checks++; if (bus.readAddress !== exp) begin errors++; $display("FAIL ovf_bl_%0d got %h exp %h", i, bus.readAddress, exp); end
      if (i == 3) begin
        checks++; if (bus.rasFull !== 1'b1 || bus.rasOverflow !== 1'b0) begin errors++; $display("FAIL ovf_full4 got full %b ovf %b exp 1 0", bus.rasFull, bus.rasOverflow); end
      end
    end
    clear_inputs();
    checks++; if (bus.rasFull !== 1'b1 || bus.rasOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flags got full %b ovf %b exp 1 1", bus.rasFull, bus.rasOverflow); end
    for (int i = 0; i < 4; i++) begin
      bus.returnFlag = 1'b1;
      tick();
      exp = 32'h1404 - 32'(256 * i);
      checks++; if (bus.readAddress !== exp) begin errors++; $display("FAIL ovf_ret_%0d got %h exp %h", i, bus.readAddress, exp); end
      if (i == 0) begin
        checks++; if (bus.rasFull !== 1'b0) begin errors++; $display("FAIL ovf_unfull got %b exp 0", bus.rasFull); end
      end
    end
    checks++; if (bus.rasEmpty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", bus.rasEmpty); end
    bus.registerTarget = 32'h777;
    tick();
    checks++; if (bus.readAddress !== 32'h774 || bus.rasOverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got pc %h ovf %b exp 774 1", bus.readAddress, bus.rasOverflow); end
    clear_inputs();
  endtask

  task automatic test_wrap_priority();
    do_reset();
    set_pc(32'hFFFFFFFC);
    checks++; if (bus.readAddress !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_setup got %h exp %h", bus.readAddress, 32'hFFFFFFFC); end
    tick();
    checks++; if (bus.readAddress !== 32'h0) begin errors++; $display("FAIL wrap_seq got %h exp 0", bus.readAddress); end
    bus.unconditionalBranchFlag = 1'b1; bus.linkFlag = 1'b1; bus.PCOffsetOrig = 26'h10;
    tick();
    checks++; if (bus.readAddress !== 32'h40 || bus.linkAddress !== 32'h4) begin errors++; $display("FAIL pri_bl got pc %h link %h exp 40 4", bus.readAddress, bus.linkAddress); end
    bus.returnFlag = 1'b1; bus.registerBranch = 1'b1; bus.registerTarget = 32'h900;
    tick();
    checks++; if (bus.readAddress !== 32'h4 || bus.rasEmpty !== 1'b1) begin errors++; $display("FAIL pri_ret got pc %h empty %b exp 4 1", bus.readAddress, bus.rasEmpty); end
    bus.returnFlag = 1'b0; bus.registerTarget = 32'h902; bus.PCOffsetOrig = 26'd8;
    tick();
    checks++; if (bus.readAddress !== 32'h900 || bus.rasEmpty !== 1'b1 || bus.linkAddress !== 32'h4) begin
      errors++; $display("FAIL pri_br got pc %h empty %b link %h exp 900 1 4", bus.readAddress, bus.rasEmpty, bus.linkAddress);
    end
    bus.registerBranch = 1'b0; bus.PCOffsetOrig = 26'd4;
    tick();
    checks++; if (bus.readAddress !== 32'h910 || bus.linkAddress !== 32'h904) begin errors++; $display("FAIL pri_bl2 got pc %h link %h exp 910 904", bus.readAddress, bus.linkAddress); end
    clear_inputs();
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (bus.readAddress !== 32'h100 || bus.PCScaledOffset !== 32'h0 || bus.linkAddress !== 32'h0) begin
      errors++; $display("FAIL async_rst got pc %h scaled %h link %h exp 100 0 0", bus.readAddress, bus.PCScaledOffset, bus.linkAddress);
    end
    checks++; if (bus.rasEmpty !== 1'b1 || bus.rasFull !== 1'b0) begin errors++; $display("FAIL async_rst_ras got empty %b full %b exp 1 0", bus.rasEmpty, bus.rasFull); end
    resetN = 1'b1;
    tick();
    checks++; if (bus.readAddress !== 32'h104) begin errors++; $display("FAIL async_rst_resume got %h exp %h", bus.readAddress, 32'h104); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetN = 1'b0;
    clear_inputs();
    test_reset();
    test_cbz();
    test_stall();
    test_bl_ret();
    test_ras_overflow();
    test_wrap_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
